// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: fills one 8-word (16-byte) cache block from main memory.
//   Requests eight consecutive words starting at the block base and writes
//   each returned word into the data array in arrival order. It writes the
//   tag on the eighth return, then goes back to IDLE.
// Ports:
//   clk, rst           - clock and asynchronous active-high reset
//   miss_detected      - miss seen by the owning cache (sampled in IDLE only)
//   miss_address       - byte address of the missing access
//   memory_data_valid  - one word returned by memory this cycle (in order)
//   fsm_busy           - fill in progress (pipeline stall)
//   memory_read        - word request strobe
//   memory_address     - byte address of the current request
//   write_data_array   - write returned word into the data array
//   data_word_index    - word slot 0-7 for write_data_array
//   write_tag_array    - write tag / set valid for the filled block
//   fill_base          - block base of the current or most recent fill
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        memory_read,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic [2:0]  data_word_index,
  output logic        write_tag_array,
  output logic [15:0] fill_base
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_FILL = 1'b1;

  localparam logic [CNT_W-1:0]  WORDS_PER_BLOCK = CNT_W'(8);
  localparam logic [CNT_W-1:0]  LAST_WORD       = CNT_W'(7);
  localparam logic [ADDR_W-1:0] BLOCK_MASK      = 16'hFFF0;

  logic              r_state;
  logic              w_state_nxt;
  logic [CNT_W-1:0]  r_req_cnt;
  logic [CNT_W-1:0]  w_req_cnt_nxt;
  logic [CNT_W-1:0]  r_rcv_cnt;
  logic [CNT_W-1:0]  w_rcv_cnt_nxt;
  logic [ADDR_W-1:0] r_fill_base;
  logic [ADDR_W-1:0] w_fill_base_nxt;

  // State, counters and block base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_req_cnt   <= '0;
      r_rcv_cnt   <= '0;
      r_fill_base <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_cnt   <= w_req_cnt_nxt;
      r_rcv_cnt   <= w_rcv_cnt_nxt;
      r_fill_base <= w_fill_base_nxt;
    end
  end

  // Next state and outputs. Outputs depend only on registered state plus
  // the current memory_data_valid, so the tag write can coincide with the
  // last returned word.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_cnt_nxt    = r_req_cnt;
    w_rcv_cnt_nxt    = r_rcv_cnt;
    w_fill_base_nxt  = r_fill_base;
    fsm_busy         = 1'b0;
    memory_read      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_word_index  = '0;
    write_tag_array  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Returns arriving in IDLE (e.g. after a reset) are dropped here.
        if (miss_detected) begin
          w_state_nxt     = ST_FILL;
          w_fill_base_nxt = miss_address & BLOCK_MASK;
          w_req_cnt_nxt   = '0;
          w_rcv_cnt_nxt   = '0;
        end
      end

      ST_FILL: begin
        fsm_busy = 1'b1;
        // Requests issue back to back; req_cnt parks at 8 once all are out.
        if (r_req_cnt < WORDS_PER_BLOCK) begin
          memory_read    = 1'b1;
          memory_address = r_fill_base + {12'h000, r_req_cnt[2:0], 1'b0};
          w_req_cnt_nxt  = r_req_cnt + CNT_W'(1);
        end
        write_data_array = memory_data_valid;
        data_word_index  = r_rcv_cnt[2:0];
        if (memory_data_valid) begin
          w_rcv_cnt_nxt = r_rcv_cnt + CNT_W'(1);
          if (r_rcv_cnt == LAST_WORD) begin
            write_tag_array = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign fill_base = r_fill_base;

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameters: none; all widths fixed (16-bit byte address, 16-bit word, 8-word/16-byte block).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 miss_detected  input  1  cache miss seen this cycle by the owning cache.
REQ-005 miss_address  input  16  byte address of the missing access.
REQ-006 memory_data_valid  input  1  main memory returns one word this cycle, in request order.
REQ-007 fsm_busy  output  1  fill in progress; the stall source for the pipeline.
REQ-008 memory_read  output  1  request one word from main memory this cycle.
REQ-009 memory_address  output  16  byte address of the current memory request.
REQ-010 write_data_array  output  1  write the returned word into the data array.
REQ-011 data_word_index  output  3  word slot (0-7) within the block for write_data_array.
REQ-012 write_tag_array  output  1  write the tag and set the valid bit for the filled block.
REQ-013 fill_base  output  16  registered block base address of the current or most recent fill.

Function
REQ-014 Two states SHALL exist: IDLE and FILL; fsm_busy = (state == FILL), decoded from registered state only.
REQ-015 In IDLE with miss_detected=1, the next edge SHALL enter FILL, latch fill_base = miss_address & 16'hFFF0, and clear req_cnt (4 bit) and rcv_cnt (4 bit).
REQ-016 In IDLE with miss_detected=0, state, fill_base and counters SHALL hold.
REQ-017 In FILL with req_cnt < 8: memory_read=1, memory_address = fill_base + {req_cnt[2:0],1'b0}, req_cnt increments each edge; requests thus occupy the first 8 FILL cycles, one per cycle, with no gaps.
REQ-018 With req_cnt == 8, memory_read SHALL be 0; req_cnt saturates and does not wrap.
REQ-019 Outside FILL, memory_read=0 and memory_address=16'h0000.
REQ-020 In FILL: write_data_array = memory_data_valid; data_word_index = rcv_cnt[2:0]; rcv_cnt increments on each valid.
REQ-021 Returns may overlap outstanding requests (pipelined memory, nominal 4-cycle latency); correctness SHALL NOT depend on latency value.
REQ-022 In FILL with memory_data_valid=1 and rcv_cnt == 7, write_tag_array SHALL assert combinationally in that same cycle, and the next edge SHALL return to IDLE.
REQ-023 write_tag_array SHALL be high for exactly one cycle per fill; write_data_array exactly eight cycles per fill.
REQ-024 miss_detected during FILL SHALL be ignored; fill_base SHALL NOT change until the next IDLE acceptance.
REQ-025 memory_data_valid in IDLE SHALL be ignored: no writes, no counter change.
REQ-026 miss_detected on the first IDLE cycle after a fill SHALL start a new fill (back-to-back, one idle cycle minimum).
REQ-027 Address arithmetic SHALL be 16-bit; base 16'hFFF0 yields last request 16'hFFFE, with no carry out.
REQ-028 All outputs SHALL be glitch-free functions of registered state, counters and the current memory_data_valid only.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, req_cnt=0, rcv_cnt=0, fill_base=16'h0000; fsm_busy, memory_read, write_data_array and write_tag_array SHALL be 0; memory_address=0; data_word_index=0.
REQ-030 Reset mid-fill SHALL abandon the fill without any tag write; words returning after reset release SHALL be ignored per REQ-025.
REQ-031 First edge after rst deassertion SHALL evaluate IDLE normally.

Verification
REQ-032 Basic fill: miss_address=16'h1234, 4-cycle memory -> fill_base=16'h1230; reads at 1230,1232,...,123E on consecutive cycles; 8 data writes with index 0-7; write_tag_array coincides with the 8th valid; fsm_busy high for 12 cycles.
REQ-033 Miss during fill: assert miss_detected at 16'h5000 mid-fill -> ignored; fill_base stays 16'h1230; no extra reads.
REQ-034 Reset mid-fill: rst after the 3rd returned word -> outputs zero immediately; no write_tag_array; stray memory_data_valid afterward produces no writes.
REQ-035 Top-of-memory: miss_address=16'hFFFF -> fill_base=16'hFFF0; last request 16'hFFFE; exactly 8 requests.
REQ-036 Back-to-back fills: second miss at 16'h0040 on the first IDLE cycle -> new fill starts next edge with req_cnt and rcv_cnt cleared and indices restarting at 0.
REQ-037 Irregular returns: memory_data_valid with random gaps (latency 1-10 cycles) -> exactly 8 in-order data writes, one tag write, and return to IDLE after the 8th.
